// File: rtl/lr_processor_if.sv
// lr_processor_if: LR (Avalon-style) bus between the core master and the byte memory slave
interface lr_processor_if;
    logic       LRMasterRD_o;
    logic       LRMasterWR_o;
    logic [7:0] LRMasterRDData_i;
    logic [7:0] LRMasterWRData_o;
    logic [7:0] LRMasterAddr_o;
    modport master (
        output LRMasterRD_o, LRMasterWR_o, LRMasterWRData_o, LRMasterAddr_o,
        input  LRMasterRDData_i
    );
    modport slave (
        input  LRMasterRD_o, LRMasterWR_o, LRMasterWRData_o, LRMasterAddr_o,
        output LRMasterRDData_i
    );
endinterface

// File: rtl/lr_processor.sv
// lr_processor: 8-bit accumulator core driving the LR bus from a multi-cycle FSM
module lr_processor #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input logic            clk,
    input logic            rstn,
    lr_processor_if.master bus
);
    typedef enum logic [2:0] {FETCH0, FETCH1, DECODE, MEMRD, EXEC, MEMWR, HALT} state_t;
    state_t     state;
    logic [7:0] pc, a, ir, opr, d, res;
    logic       z, c, cres;
    logic [8:0] sum, diff;
    assign d = bus.LRMasterRDData_i;
    // ALU: d is the immediate in DECODE and the memory byte in EXEC; diff[8] is the borrow
    always_comb begin
        sum  = {1'b0, a} + {1'b0, d};
        diff = {1'b0, a} - {1'b0, d};
        res  = ir[3:0] == 4'h2 ? d :
               ir[3:0] == 4'h4 ? sum[7:0] :
               ir[3:0] == 4'h5 ? diff[7:0] :
               ir[3:0] == 4'h6 ? a & d :
               ir[3:0] == 4'h7 ? a | d : a ^ d;
        cres = ir[3:0] == 4'h2 ? c :
               ir[3:0] == 4'h4 ? sum[8] :
               ir[3:0] == 4'h5 ? diff[8] : 1'b0;
    end
    // Moore bus decode; reset forces the bus idle so a pending access is dropped at once
    always_comb begin
        bus.LRMasterRD_o     = !rstn && (state == FETCH0 || state == FETCH1 || state == MEMRD);
        bus.LRMasterWR_o     = !rstn && state == MEMWR;
        bus.LRMasterAddr_o   = rstn ? 8'h00 :
                               state == FETCH0 ? pc :
                               state == FETCH1 ? pc + 8'd1 :
                               (state == MEMRD || state == MEMWR) ? opr : 8'h00;
        bus.LRMasterWRData_o = (!rstn && state == MEMWR) ? a : 8'h00;
    end
    // Sequencer and architectural state; immediates and jumps finish in DECODE
    always_ff @(posedge clk) begin
        if (rstn) begin
            state <= FETCH0;
            pc    <= RESET_PC;
            a     <= 8'h00;
            ir    <= 8'h00;
            opr   <= 8'h00;
            z     <= 1'b0;
            c     <= 1'b0;
        end else begin
            case (state)
                FETCH0: state <= FETCH1;
                FETCH1: begin
                    ir    <= d;
                    state <= DECODE;
                end
                DECODE: begin
                    opr   <= d;
                    pc    <= pc + 8'd2;
                    state <= FETCH0;
                    case (ir[3:0])
                        4'h1: begin
                            a <= d;
                            z <= d == 8'h00;
                        end
                        4'h2, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: state <= MEMRD;
                        4'h3: state <= MEMWR;
                        4'h9: pc <= d;
                        4'hA: if (z) pc <= d;
                        4'hB: if (c) pc <= d;
                        4'hC: begin
                            {c, a} <= sum;
                            z      <= sum[7:0] == 8'h00;
                        end
                        4'hF: state <= HALT;
                        default: ;
                    endcase
                end
                MEMRD: state <= EXEC;
                EXEC: begin
                    a     <= res;
                    c     <= cres;
                    z     <= res == 8'h00;
                    state <= FETCH0;
                end
                MEMWR: state <= FETCH0;
                default: state <= HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_lr_processor.sv
// tb_lr_processor: checks the per-cycle bus trace against an instruction-level reference model
module tb_lr_processor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lr_processor_if bus ();
    lr_processor dut (.clk(clk), .rstn(rst), .bus(bus));

    logic [7:0] mem [64];
    logic [7:0] img [64];
    logic [7:0] rddata;
    assign bus.LRMasterRDData_i = rddata;

    // 64-byte slave, read latency 1; the image is reloaded while reset is held
    always @(posedge clk) begin
        if (bus.LRMasterRD_o) rddata <= mem[bus.LRMasterAddr_o[5:0]];
        if (bus.LRMasterWR_o) mem[bus.LRMasterAddr_o[5:0]] <= bus.LRMasterWRData_o;
        else if (rst) mem <= img;
    end

    int n_cmp = 0;
    int n_err = 0;
    int wr_seen = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: executes whole instructions and emits the bus cycles each one costs
    logic [17:0] exp_q [$];
    logic [7:0]  m_pc, m_a;
    logic        m_z, m_c, m_halt;
    logic [7:0]  mm [64];

    function automatic logic [17:0] cyc(input logic rd, input logic wr, input logic [7:0] ad, input logic [7:0] wd);
        return {rd, wr, ad, wd};
    endfunction

    task automatic model_reset();
        m_pc = 8'h00; m_a = 8'h00; m_z = 1'b0; m_c = 1'b0; m_halt = 1'b0;
        mm = img;
        exp_q.delete();
    endtask

    task automatic model_step();
        logic [7:0] op, k, m, npc;
        logic [8:0] t;
        if (m_halt) begin
            exp_q.push_back(18'h0);
            return;
        end
        op  = mm[m_pc[5:0]];
        npc = m_pc + 8'd1;
        k   = mm[npc[5:0]];
        exp_q.push_back(cyc(1, 0, m_pc, 0));
        exp_q.push_back(cyc(1, 0, npc, 0));
        exp_q.push_back(18'h0);
        npc = m_pc + 8'd2;
        case (op[3:0])
            4'h1: begin m_a = k; m_z = (m_a == 0); end
            4'h2, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
                exp_q.push_back(cyc(1, 0, k, 0));
                exp_q.push_back(18'h0);
                m = mm[k[5:0]];
                case (op[3:0])
                    4'h2: m_a = m;
                    4'h4: begin t = m_a + m; m_c = t > 255; m_a = t[7:0]; end
                    4'h5: begin m_c = m_a < m; m_a = m_a - m; end
                    4'h6: begin m_a = m_a & m; m_c = 0; end
                    4'h7: begin m_a = m_a | m; m_c = 0; end
                    default: begin m_a = m_a ^ m; m_c = 0; end
                endcase
                m_z = (m_a == 0);
            end
            4'h3: begin exp_q.push_back(cyc(0, 1, k, m_a)); mm[k[5:0]] = m_a; end
            4'h9: npc = k;
            4'hA: if (m_z) npc = k;
            4'hB: if (m_c) npc = k;
            4'hC: begin t = m_a + k; m_c = t > 255; m_a = t[7:0]; m_z = (m_a == 0); end
            4'hF: m_halt = 1'b1;
            default: ;
        endcase
        m_pc = npc;
    endtask

    function automatic logic [17:0] bus_now();
        return {bus.LRMasterRD_o, bus.LRMasterWR_o, bus.LRMasterAddr_o, bus.LRMasterWRData_o};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1 chk("reset_idle", bus_now(), 0);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        wr_seen = 0;
    endtask

    task automatic run(input string tag, input int n);
        while (exp_q.size() < n) model_step();
        for (int i = 0; i < n; i++) begin
            #1;
            chk(tag, bus_now(), exp_q.pop_front());
            chk("rd_wr_excl", bus.LRMasterRD_o & bus.LRMasterWR_o, 0);
            wr_seen += bus.LRMasterWR_o;
            @(negedge clk);
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < 64; i++) img[i] = 8'h00;
    endtask

    initial begin
        // first two cycles after reset fetch 0x00 then 0x01
        clear_img();
        img[0] = 8'h0F;
        do_reset();
        #1 chk("first_fetch", bus_now(), cyc(1, 0, 8'h00, 0));
        @(negedge clk);
        #1 chk("second_fetch", bus_now(), cyc(1, 0, 8'h01, 0));
        @(negedge clk);

        // LDI 05; ADD 20; ST 21; HLT
        clear_img();
        {img[0], img[1], img[2], img[3], img[4], img[5], img[6]} = {8'h01, 8'h05, 8'h04, 8'h20, 8'h03, 8'h21, 8'h0F};
        img[8'h20] = 8'h03;
        do_reset();
        run("prog_add", 30);
        chk("add_store", mem[8'h21], 8'h08);
        chk("add_wr_count", wr_seen, 1);

        // LDI FF; ADDI 01; JZ 10 -> fetch at 0x10, then expose A and C
        clear_img();
        {img[0], img[1], img[2], img[3], img[4], img[5]} = {8'h01, 8'hFF, 8'h0C, 8'h01, 8'h0A, 8'h10};
        {img[8'h10], img[8'h11], img[8'h12], img[8'h13], img[8'h14]} = {8'h03, 8'h22, 8'h0B, 8'h16, 8'h0F};
        img[8'h16] = 8'h0F;
        img[8'h22] = 8'h55;
        do_reset();
        run("prog_addi", 30);
        chk("addi_store", mem[8'h22], 8'h00);

        // LDI 02; SUB 20; JZ 30 not taken -> 0x06
        clear_img();
        {img[0], img[1], img[2], img[3], img[4], img[5]} = {8'h01, 8'h02, 8'h05, 8'h20, 8'h0A, 8'h30};
        {img[6], img[7], img[8], img[9], img[10]} = {8'h03, 8'h21, 8'h0B, 8'h00, 8'h0F};
        img[8'h20] = 8'h03;
        do_reset();
        run("prog_sub", 40);
        chk("sub_store", mem[8'h21], 8'hFF);

        // reset during the MEMWR of ST 21; the restart's ST 22 shows A was cleared
        clear_img();
        {img[0], img[1], img[2], img[3], img[4], img[5], img[6]} = {8'h03, 8'h22, 8'h01, 8'h05, 8'h03, 8'h21, 8'h0F};
        img[8'h22] = 8'h77;
        do_reset();
        run("prog_mid", 10);
        #1 chk("mid_wr", bus_now(), cyc(0, 1, 8'h21, 8'h05));
        rst = 1'b1;
        @(negedge clk);
        #1 chk("mid_abort", {bus.LRMasterRD_o, bus.LRMasterWR_o}, 0);
        chk("mid_nowrite", mem[8'h21], 8'h00);
        do_reset();
        run("prog_restart", 20);
        chk("restart_a0", mem[8'h22], 8'h00);

        // LDI 07; undefined 0D; ST 23; JMP 02 loop
        clear_img();
        {img[0], img[1], img[2], img[3], img[4], img[5], img[6], img[7]} = {8'h01, 8'h07, 8'h0D, 8'h55, 8'h03, 8'h23, 8'h09, 8'h02};
        do_reset();
        run("prog_loop", 45);
        chk("loop_store", mem[8'h23], 8'h07);

        // random programs and data
        for (int t = 0; t < 15; t++) begin
            for (int i = 0; i < 64; i++) img[i] = 8'($urandom);
            do_reset();
            run("random", 150);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/lr_processor.md
Name: lr_processor

Overview:
- 8-bit accumulator microcontroller core; single master on the LR (Avalon-style) bus.
- Fetches instructions from, and loads/stores data to, one shared byte memory: the 64-byte AvalonMem slave, addressed on Addr[5:0].
- Multi-cycle FSM; never more than one bus access per cycle.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rstn  in  1  synchronous, active-high reset. Despite the name, asserted = 1.
- LRMasterRD_o  out  1  read strobe, one cycle per read.
- LRMasterWR_o  out  1  write strobe, one cycle per write.
- LRMasterRDData_i  in  8  read data. Valid the cycle after the RD cycle (read latency 1).
- LRMasterWRData_o  out  8  write data.
- LRMasterAddr_o  out  8  bus address.

Behaviour:
- Registers: PC[7:0], A[7:0], IR[7:0], OPR[7:0], Z, C.
- Reset: PC=RESET_PC, A=0, IR=0, OPR=0, Z=0, C=0, state=FETCH0. While reset is asserted, RD=0, WR=0, Addr=0, WRData=0. Reset mid-operation aborts any pending read or write.
- Bus outputs are decoded from the current state (Moore). RD and WR are never both 1. Outside RD/WR cycles, Addr=0 and WRData=0.
- Instruction format: 2 bytes, opcode at PC, operand at PC+1. PC arithmetic is 8-bit with wrap (0xFF+1=0x00).
- FSM states and transitions:
  - FETCH0: RD=1, Addr=PC. Next: FETCH1.
  - FETCH1: RD=1, Addr=PC+1; IR<=RDData. Next: DECODE.
  - DECODE: OPR<=RDData; PC<=PC+2. Immediate, jump, NOP and undefined opcodes complete here, then go to FETCH0. LD/ALU ops go to MEMRD. ST goes to MEMWR. HLT goes to HALT.
  - MEMRD: RD=1, Addr=OPR. Next: EXEC.
  - EXEC: operate on RDData. Next: FETCH0.
  - MEMWR: WR=1, Addr=OPR, WRData=A. Next: FETCH0.
  - HALT: no bus activity. Leaves only on reset.
- Cycle counts: imm/jump/NOP = 3, ST = 4, LD/ALU = 5.
- Opcodes (IR[3:0]; IR[7:4] ignored). M = memory byte at OPR, K = OPR:
  - 0 NOP.
  - 1 LDI: A=K.
  - 2 LD: A=M.
  - 3 ST: M<=A.
  - 4 ADD: {C,A}=A+M.
  - 5 SUB: A=A-M, C=borrow (1 when A<M).
  - 6 AND: A=A&M.
  - 7 OR: A=A|M.
  - 8 XOR: A=A^M.
  - 9 JMP: PC=K.
  - A JZ: if Z, PC=K.
  - B JC: if C, PC=K.
  - C ADDI: {C,A}=A+K.
  - F HLT.
  - D, E: treated as NOP.
- Flag rules:
  - Z=(A_new==0) after LDI, LD, ADD, SUB, AND, OR, XOR, ADDI.
  - AND/OR/XOR clear C. LDI and LD leave C unchanged.
  - ST, jumps, NOP and HLT leave flags unchanged.
- Jump target overrides the PC+2 update in the same DECODE cycle. Not-taken jump = PC+2.
- ALU arithmetic is modulo 256 on A; carry/borrow only in C.

Test Plan:
- Reset: hold rstn=1 for 3 cycles → RD=WR=0, Addr=0. On the first cycle after release, RD=1 and Addr=0x00; the next cycle, RD=1 and Addr=0x01.
- Program `LDI 05; ADD 20; ST 21; HLT` with M[0x20]=03 → one WR cycle with Addr=0x21, WRData=0x08. Z=0, C=0. No bus activity after HLT. Total 3+5+4+3 cycles to HALT.
- Program `LDI FF; ADDI 01; JZ 10` → A=00, Z=1, C=1. Next fetch is RD at Addr=0x10.
- Program `LDI 02; SUB 20` with M[0x20]=03, then `JZ 30` → A=FF, C=1, Z=0. JZ not taken; next fetch at Addr=0x06.
- Reset mid-store: assert rstn during the MEMWR cycle → WR=0 the next cycle. After release, fetch restarts at Addr=0x00 with A=0.
- Undefined opcode 0xD then `JMP 00` → no flag/A change; PC advances by 2 and the loop fetches 0x00 repeatedly. Also check that RD and WR are never asserted together.
